// File: rtl/ex_stage_controller.sv
// Execute-stage sequencer: holds one decoded instruction, drives datapath selects,
// evaluates its condition against the NZCV register and retires it to MEM.
//
// state | meaning
// IDLE  | EX empty, ready for an instruction from ID
// EXEC  | instruction in EX, waiting for mem_ready to retire
// FLUSH | taken branch retired, front end killed for 2 cycles
module ex_stage_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_valid,
  output logic       id_ready,
  input  logic [1:0] id_class,
  input  logic [3:0] id_cond,
  input  logic [3:0] id_opcode,
  input  logic       id_s,
  input  logic       id_imm,
  input  logic       id_up,
  input  logic       alu_n,
  input  logic       alu_z,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       mem_ready,
  output logic [3:0] alu_op,
  output logic [2:0] sse_cmd,
  output logic       op2_sel,
  output logic       addr_sel,
  output logic [3:0] flags,
  output logic       ex_valid,
  output logic       branch_taken,
  output logic       flush
);

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_FLUSH} state_t;

  localparam logic [1:0] CLS_DP  = 2'b00;
  localparam logic [1:0] CLS_LS  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_NOP = 2'b11;

  state_t     state, state_nxt;
  logic       flush_cnt, flush_cnt_nxt;
  logic [1:0] ex_class;
  logic [3:0] ex_cond;
  logic [3:0] ex_opcode;
  logic       ex_s, ex_imm, ex_up;
  logic       cond_pass, accept, retire, br_take, flag_we, arith;
  logic       f_n, f_z, f_c, f_v;

  assign {f_n, f_z, f_c, f_v} = flags;

  always_comb begin
    cond_pass = 1'b0;
    case (ex_cond)
      4'b0000: cond_pass = f_z;
      4'b0001: cond_pass = !f_z;
      4'b0010: cond_pass = f_c;
      4'b0011: cond_pass = !f_c;
      4'b0100: cond_pass = f_n;
      4'b0101: cond_pass = !f_n;
      4'b0110: cond_pass = f_v;
      4'b0111: cond_pass = !f_v;
      4'b1000: cond_pass = f_c && !f_z;
      4'b1001: cond_pass = !f_c || f_z;
      4'b1010: cond_pass = (f_n == f_v);
      4'b1011: cond_pass = (f_n != f_v);
      4'b1100: cond_pass = !f_z && (f_n == f_v);
      4'b1101: cond_pass = f_z || (f_n != f_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  assign accept  = id_valid && id_ready;
  assign retire  = (state == ST_EXEC) && mem_ready;
  assign br_take = (ex_class == CLS_BR) && cond_pass;
  // Compare/test opcodes (1000-1011) update flags even without the S bit.
  assign flag_we = retire && cond_pass && (ex_class == CLS_DP) &&
                   (ex_s || (ex_opcode[3:2] == 2'b10));
  assign arith   = (ex_opcode[3:1] == 3'b001) || (ex_opcode[3:1] == 3'b010) ||
                   (ex_opcode[3:1] == 3'b011) || (ex_opcode[3:1] == 3'b101);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      ST_IDLE: if (id_valid) state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (mem_ready) begin
          if (br_take) begin
            state_nxt     = ST_FLUSH;
            flush_cnt_nxt = 1'b1;
          end else if (id_valid) begin
            state_nxt = ST_EXEC;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_FLUSH: begin
        if (flush_cnt == 1'b0) state_nxt = ST_IDLE;
        else                   flush_cnt_nxt = flush_cnt - 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    id_ready     = 1'b0;
    flush        = 1'b0;
    ex_valid     = 1'b0;
    branch_taken = 1'b0;
    case (state)
      ST_IDLE: id_ready = 1'b1;
      ST_EXEC: begin
        id_ready     = mem_ready;
        ex_valid     = cond_pass && ((ex_class == CLS_DP) || (ex_class == CLS_LS));
        branch_taken = br_take && mem_ready;
      end
      ST_FLUSH: flush = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    alu_op   = 4'b0100;
    sse_cmd  = 3'b001;
    op2_sel  = 1'b1;
    addr_sel = 1'b0;
    case (ex_class)
      CLS_DP: begin
        alu_op  = ex_opcode;
        sse_cmd = ex_imm ? 3'b001 : 3'b000;
        op2_sel = ex_imm;
      end
      CLS_LS: begin
        alu_op   = ex_up ? 4'b0100 : 4'b0010;
        sse_cmd  = ex_imm ? 3'b010 : 3'b011;
        op2_sel  = ex_imm;
        addr_sel = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_class  <= CLS_NOP;
      ex_cond   <= 4'b0000;
      ex_opcode <= 4'b0000;
      ex_s      <= 1'b0;
      ex_imm    <= 1'b0;
      ex_up     <= 1'b0;
    end else if (accept) begin
      ex_class  <= id_class;
      ex_cond   <= id_cond;
      ex_opcode <= id_opcode;
      ex_s      <= id_s;
      ex_imm    <= id_imm;
      ex_up     <= id_up;
    end
  end

  // Logical ops leave C and V untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        flags <= 4'b0000;
    else if (flag_we) flags <= arith ? {alu_n, alu_z, alu_c, alu_v}
                                     : {alu_n, alu_z, flags[1:0]};
  end

endmodule

// File: tb/tb_ex_stage_controller.sv
// Scoreboard bench for ex_stage_controller: predictions are queued when an
// instruction is presented and compared cycle by cycle while it sits in EX.
module tb_ex_stage_controller;

  logic       clk, reset, id_valid, id_ready;
  logic [1:0] id_class;
  logic [3:0] id_cond, id_opcode;
  logic       id_s, id_imm, id_up;
  logic       alu_n, alu_z, alu_c, alu_v, mem_ready;
  logic [3:0] alu_op, flags;
  logic [2:0] sse_cmd;
  logic       op2_sel, addr_sel, ex_valid, branch_taken, flush;

  ex_stage_controller dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_ready(id_ready),
    .id_class(id_class), .id_cond(id_cond), .id_opcode(id_opcode),
    .id_s(id_s), .id_imm(id_imm), .id_up(id_up),
    .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .mem_ready(mem_ready), .alu_op(alu_op), .sse_cmd(sse_cmd),
    .op2_sel(op2_sel), .addr_sel(addr_sel), .flags(flags),
    .ex_valid(ex_valid), .branch_taken(branch_taken), .flush(flush)
  );

  typedef struct packed {
    logic [3:0] aluop;
    logic [2:0] sse;
    logic       op2, addr, exv, br;
    logic [3:0] fb, fa, aluf;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       last_e;
  logic [3:0] m_flags;
  int         n_checks = 0;
  int         n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic exp_t predict(input logic [1:0] cls, input logic [3:0] cond, op,
                                   input logic s, imm, up, input logic [3:0] aluf);
    exp_t e;
    logic n, z, c, v, p;
    {n, z, c, v} = m_flags;
    case (cond)
      4'd0: p = z;            4'd1: p = !z;
      4'd2: p = c;            4'd3: p = !c;
      4'd4: p = n;            4'd5: p = !n;
      4'd6: p = v;            4'd7: p = !v;
      4'd8: p = c & !z;       4'd9: p = !c | z;
      4'd10: p = (n == v);    4'd11: p = (n != v);
      4'd12: p = !z & (n == v);
      4'd13: p = z | (n != v);
      4'd14: p = 1'b1;
      default: p = 1'b0;
    endcase
    case (cls)
      2'd0: begin e.aluop = op; e.sse = imm ? 3'd1 : 3'd0; e.op2 = imm; e.addr = 1'b0; end
      2'd1: begin e.aluop = up ? 4'd4 : 4'd2; e.sse = imm ? 3'd2 : 3'd3; e.op2 = imm; e.addr = 1'b1; end
      default: begin e.aluop = 4'd4; e.sse = 3'd1; e.op2 = 1'b1; e.addr = 1'b0; end
    endcase
    e.exv  = p && (cls < 2'd2);
    e.br   = p && (cls == 2'd2);
    e.fb   = m_flags;
    e.aluf = aluf;
    e.fa   = m_flags;
    if (p && cls == 2'd0 && (s || (op >= 4'd8 && op <= 4'd11))) begin
      if (op inside {4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd10, 4'd11}) e.fa = aluf;
      else e.fa = {aluf[3:2], m_flags[1:0]};
    end
    return e;
  endfunction

  // Called before an edge; returns at the negedge after the acceptance edge.
  task automatic present(input logic [1:0] cls, input logic [3:0] cond, op,
                         input logic s, imm, up, input logic [3:0] aluf);
    exp_t e;
    e = predict(cls, cond, op, s, imm, up, aluf);
    m_flags = e.fa;
    sb_q.push_back(e);
    id_class = cls; id_cond = cond; id_opcode = op;
    id_s = s; id_imm = imm; id_up = up;
    id_valid = 1'b1;
    #1;
    chk("id_ready_accept", id_ready, 1'b1);
    @(negedge clk);
    id_valid = 1'b0;
  endtask

  // Walks the instruction through EX; returns inside its retire cycle.
  task automatic exec_phase(input int stall);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 1'b1, 1'b0);
      return;
    end
    e = sb_q.pop_front();
    last_e = e;
    {alu_n, alu_z, alu_c, alu_v} = e.aluf;
    for (int i = 0; i <= stall; i++) begin
      mem_ready = (i == stall);
      #1;
      chk("alu_op", alu_op, e.aluop);
      chk("sse_cmd", sse_cmd, e.sse);
      chk("op2_sel", op2_sel, e.op2);
      chk("addr_sel", addr_sel, e.addr);
      chk("ex_valid", ex_valid, e.exv);
      chk("id_ready_ex", id_ready, (i == stall));
      chk("branch_taken", branch_taken, (i == stall) && e.br);
      chk("flags_before", flags, e.fb);
      chk("flush_ex", flush, 1'b0);
      if (i < stall) @(negedge clk);
    end
  endtask

  task automatic finish_retire();
    @(negedge clk);
    #1;
    chk("flags_after", flags, last_e.fa);
    chk("flush_t", flush, last_e.br);
    chk("id_ready_t", id_ready, !last_e.br);
    chk("branch_taken_t", branch_taken, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_class = 2'b11; id_cond = 4'd0; id_opcode = 4'd0;
    id_s = 1'b0; id_imm = 1'b0; id_up = 1'b0; mem_ready = 1'b1;
    {alu_n, alu_z, alu_c, alu_v} = 4'b0000;
    m_flags = 4'b0000;
    #2;
    chk("rst_flags", flags, 4'b0000);
    chk("rst_id_ready", id_ready, 1'b1);
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_branch", branch_taken, 1'b0);
    chk("rst_alu_op", alu_op, 4'b0100);
    chk("rst_sse", sse_cmd, 3'b001);
    chk("rst_op2", op2_sel, 1'b1);
    chk("rst_addr", addr_sel, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("idle_flags", flags, 4'b0000);
      chk("idle_id_ready", id_ready, 1'b1);
      chk("idle_ex_valid", ex_valid, 1'b0);
      chk("idle_flush", flush, 1'b0);
    end
    @(negedge clk);

    // ADDS -> ANDS -> CMP back-to-back
    present(2'b00, 4'b1110, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0110);
    exec_phase(0);
    present(2'b00, 4'b1110, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b1001);
    exec_phase(0);
    present(2'b00, 4'b1110, 4'b1010, 1'b0, 1'b0, 1'b0, 4'b0001);
    exec_phase(0);
    present(2'b00, 4'b1110, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b0100);
    exec_phase(0);
    finish_retire();
    @(negedge clk);

    // BEQ taken, ID pulses during flush are ignored
    present(2'b10, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);
    exec_phase(0);
    finish_retire();
    id_class = 2'b00; id_cond = 4'b1110; id_opcode = 4'b0100; id_s = 1'b1;
    id_valid = 1'b1;
    @(negedge clk);
    #1;
    chk("flush_t1", flush, 1'b1);
    chk("id_ready_t1", id_ready, 1'b0);
    @(negedge clk);
    id_valid = 1'b0;
    #1;
    chk("flush_t2", flush, 1'b0);
    chk("id_ready_t2", id_ready, 1'b1);
    chk("ex_valid_t2", ex_valid, 1'b0);
    @(negedge clk);
    #1;
    chk("no_accept_flush", ex_valid, 1'b0);
    chk("flags_post_flush", flags, m_flags);
    @(negedge clk);

    // BNE not taken, then LDR accepted immediately and stalled 3 cycles
    present(2'b10, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
    exec_phase(0);
    present(2'b01, 4'b1110, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111);
    exec_phase(3);
    finish_retire();
    @(negedge clk);

    // never-condition ADDS
    present(2'b00, 4'b1111, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b1011);
    exec_phase(0);
    finish_retire();
    @(negedge clk);

    // reset during FLUSH
    present(2'b10, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000);
    exec_phase(0);
    finish_retire();
    reset = 1'b1;
    m_flags = 4'b0000;
    #1;
    chk("rst_flush_mid", flush, 1'b0);
    chk("rst_flags_mid", flags, 4'b0000);
    chk("rst_id_ready_mid", id_ready, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_flush", flush, 1'b0);
    chk("post_rst_id_ready", id_ready, 1'b1);
    @(negedge clk);

    // EQ after reset fails with Z=0
    present(2'b00, 4'b0000, 4'b0100, 1'b1, 1'b0, 1'b0, 4'b1111);
    exec_phase(0);
    finish_retire();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_stage_controller.md
# ex_stage_controller

Sequencer for the execute stage: ALU, shifter/sign-extender, address mux, condition handler and status register. It accepts one decoded instruction at a time from ID, drives the datapath control selects, and evaluates the condition field against an internal NZCV register. It commits flag updates and hands results to MEM under a ready/valid handshake. On a taken branch it raises a 2-cycle front-end flush.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  EX accepts the instruction this cycle
- id_class  in  2  00 data-processing, 01 load/store, 10 branch, 11 nop
- id_cond  in  4  ARM condition field
- id_opcode  in  4  data-processing opcode, ALU encoding
- id_s  in  1  S bit
- id_imm  in  1  operand 2 / offset is immediate
- id_up  in  1  load/store U bit
- alu_n, alu_z, alu_c, alu_v  in  1 each  flags the ALU produces for the instruction in EX
- mem_ready  in  1  MEM accepts this cycle
- alu_op  out  4  ALU operation select
- sse_cmd  out  3  shifter/sign-extender command
- op2_sel  out  1  1 = immediate operand to ALU B
- addr_sel  out  1  1 = shifter address to MEM (load/store)
- flags  out  4  registered {N,Z,C,V}
- ex_valid  out  1  instruction in EX passed its condition and is forwarded to MEM
- branch_taken  out  1  taken branch retiring this cycle
- flush  out  1  kill IF/ID contents

## Operation
- EX register: captures id_class/cond/opcode/s/imm/up on the clk edge where id_valid & id_ready.
- All datapath outputs decode combinationally from the EX register.
- Decode by class:
  - DP: alu_op=opcode; sse_cmd=001 if imm, else 000; op2_sel=imm; addr_sel=0.
  - LS: alu_op=0100 if up, else 0010; sse_cmd=010 if imm, else 011; op2_sel=imm; addr_sel=1.
  - Branch/nop: alu_op=0100, sse_cmd=001, op2_sel=1, addr_sel=0.
- Condition (cond_pass, evaluated against the flags register):
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C
  - 0100 N; 0101 !N; 0110 V; 0111 !V
  - 1000 C&!Z; 1001 !C|Z
  - 1010 N==V; 1011 N!=V
  - 1100 !Z&(N==V); 1101 Z|(N!=V)
  - 1110 always; 1111 never
- Flag update: only at retirement, with cond_pass, class DP, and (id_s or opcode 1000–1011).
  - Arithmetic opcodes 0010–0111, 1010, 1011: write all four flags.
  - Logical opcodes 0000, 0001, 1000, 1001, 1100–1111: write N and Z only; C and V hold.
- Failed condition: the instruction retires as a bubble. No flag write, ex_valid=0, no branch.
- States:
  - IDLE: id_ready=1. id_valid → EXEC.
  - EXEC: id_ready=mem_ready.
    - If mem_ready: retire. Taken branch → FLUSH; else id_valid → EXEC (back-to-back); else IDLE.
    - If !mem_ready: hold EX register, flags and all outputs stable.
  - FLUSH: flush=1, id_ready=0, id_valid ignored. After 2 cycles → IDLE.
- ex_valid = EXEC & cond_pass & class∈{DP,LS}.
- branch_taken = EXEC & class==branch & cond_pass & mem_ready.

## Timing
- Reset values (asynchronous, immediate, any state):
  - state IDLE, flags 0000, EX register cleared (class nop).
  - id_ready 1, ex_valid 0, branch_taken 0, flush 0.
  - alu_op 0100, sse_cmd 001, op2_sel 1, addr_sel 0.
- Latency: instruction accepted at edge k is in EX during cycle k+1. It retires at edge k+2 if mem_ready. Its flag write is visible from cycle k+2.
- Back-to-back: the following instruction's condition sees the preceding instruction's updated flags. There is no flag hazard.
- Taken branch retiring at edge t: flush=1 and id_ready=0 for cycles t..t+1 (exactly 2 cycles). id_ready=1 from cycle t+2.
- Stall: mem_ready low for n cycles extends EXEC by n cycles. branch_taken and the flag write occur only in the mem_ready cycle.
- Reset mid-EXEC or mid-FLUSH aborts: no flag write, flush drops immediately.

## Test plan
- Reset → flags=0000, id_ready=1, ex_valid=0, flush=0. Hold these values until the first id_valid.
- ADDS (class 00, op 0100, s=1, cond 1110), alu flags N0 Z1 C1 V0, mem_ready=1 → in cycle k+1: alu_op=0100, ex_valid=1. From k+2: flags=0110.
- Then ANDS (op 0000, s=1) back-to-back with alu flags N1 Z0 C0 V1 → flags=1010 (C and V preserved). Then CMP (op 1010, s=0) with 0001 → flags=0001.
- With Z=1, BEQ (class 10, cond 0000) → branch_taken=1 for one cycle, then flush=1 for 2 cycles. id_valid pulses during the flush are not accepted. Then BNE (cond 0001) → branch_taken=0, flush=0, next instruction accepted immediately.
- LDR (class 01, up=0, imm=1) with mem_ready low 3 cycles → alu_op=0010, sse_cmd=010, addr_sel=1, ex_valid=1 held stable for 4 cycles. id_ready=0 until the mem_ready cycle. flags unchanged.
- ADDS with cond 1111 → ex_valid=0, flags unchanged. Separately, assert reset during FLUSH → flush=0 and flags=0000 immediately, state IDLE.
